// File: rtl/ln_fixed.sv
// ---------------------------------------------------------------------------
// ln_fixed -- sequential fixed-point natural logarithm.
//
// Computes y = ln(x) for an unsigned Q16.16 operand and returns a signed
// Q16.16 result. The operand is split into a power of two and a mantissa
// in [1,2). The mantissa is pushed up towards 2.0 by shift-and-add factors
// (1 + 2^-k). ln of each accepted factor is subtracted from an ln(2)
// accumulator, which leaves ln(mantissa). The exponent contributes e*ln(2).
// The datapath has no general multiplier. The only product is a constant
// multiply of the small exponent.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operand valid
//   in_ready   block idle, operand is accepted on in_valid
//   x          operand, unsigned Q16.16
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   y          ln(x), signed Q16.16, two's complement
//   err        x was zero (y = 0x80000000), qualified by out_valid
//
// Parameter:
//   ITER       normalisation iterations, k = 1..ITER, legal range 12..30
//
// Build option:
//   LN_FIXED_ROUND_EN  defined   -> the Q.30 to Q.16 step rounds half-up
//                      undefined -> the Q.30 to Q.16 step truncates (floor)
// ---------------------------------------------------------------------------
module ln_fixed #(
    parameter int ITER = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ITER,
        ST_FINAL,
        ST_DONE
    } state_t;

    // ln(2) in Q4.30.
    localparam logic signed [33:0] LN2_Q30 = 34'sd744261118;
    localparam logic signed [39:0] LN2_W   = 40'sd744261118;
    localparam logic signed [39:0] Y_MAX   = 40'sd2147483647;
    localparam logic signed [39:0] Y_MIN   = -40'sd2147483648;

    // T[k] = round(ln(1 + 2^-k) * 2^30). For k >= 16 the value reduces to
    // 2^(30-k) because the higher-order terms fall below half an LSB.
    function automatic logic signed [33:0] ln_tab(input logic [4:0] k);
        logic signed [33:0] v;
        case (k)
            5'd1:    v = 34'sd435364844;
            5'd2:    v = 34'sd239598564;
            5'd3:    v = 34'sd126468572;
            5'd4:    v = 34'sd65095192;
            5'd5:    v = 34'sd33040817;
            5'd6:    v = 34'sd16647494;
            5'd7:    v = 34'sd8356010;
            5'd8:    v = 34'sd4186133;
            5'd9:    v = 34'sd2095107;
            5'd10:   v = 34'sd1048064;
            5'd11:   v = 34'sd524160;
            5'd12:   v = 34'sd262112;
            5'd13:   v = 34'sd131064;
            5'd14:   v = 34'sd65534;
            5'd15:   v = 34'sd32768;
            5'd16:   v = 34'sd16384;
            5'd17:   v = 34'sd8192;
            5'd18:   v = 34'sd4096;
            5'd19:   v = 34'sd2048;
            5'd20:   v = 34'sd1024;
            5'd21:   v = 34'sd512;
            5'd22:   v = 34'sd256;
            5'd23:   v = 34'sd128;
            5'd24:   v = 34'sd64;
            5'd25:   v = 34'sd32;
            5'd26:   v = 34'sd16;
            5'd27:   v = 34'sd8;
            5'd28:   v = 34'sd4;
            5'd29:   v = 34'sd2;
            5'd30:   v = 34'sd1;
            default: v = 34'sd0;
        endcase
        return v;
    endfunction

    state_t             r_state;
    logic [31:0]        r_x;
    logic [31:0]        r_m;      // mantissa, Q2.30, in [1,2)
    logic signed [33:0] r_acc;    // ln(mantissa) accumulator, Q4.30
    logic signed [5:0]  r_e;      // exponent, -16..15
    logic [4:0]         r_k;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_y;
    logic               r_err;

    logic [4:0]         w_p;
    logic [31:0]        w_m_norm;
    logic signed [5:0]  w_e;
    logic [32:0]        w_t;
    logic               w_take;
    logic signed [39:0] w_sum;
    logic signed [39:0] w_rnd;
    logic signed [39:0] w_shift;
    logic [31:0]        w_y_sat;

    // Leading-one position of the latched operand. The loop runs upward, so
    // the last assignment wins and w_p ends on the highest set bit.
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_x[i]) begin
                w_p = 5'(i);
            end
        end
    end

    // Put the leading one at bit 30. Only p == 31 needs a right shift, and
    // it drops the operand's LSB.
    always_comb begin
        if (w_p == 5'd31) begin
            w_m_norm = r_x >> 1;
        end else begin
            w_m_norm = r_x << (5'd30 - w_p);
        end
    end

    assign w_e    = $signed({1'b0, w_p}) - 6'sd16;

    // The candidate step m*(1+2^-k) is taken only while it stays below 2.0.
    assign w_t    = {1'b0, r_m} + {1'b0, (r_m >> r_k)};
    assign w_take = (w_t[32:31] == 2'b00);

    assign w_sum  = ($signed({{34{r_e[5]}}, r_e}) * LN2_W)
                  + $signed({{6{r_acc[33]}}, r_acc});

`ifdef LN_FIXED_ROUND_EN
    assign w_rnd  = w_sum + 40'sd8192;
`else
    assign w_rnd  = w_sum;
`endif

    assign w_shift = w_rnd >>> 14;

    always_comb begin
        if (w_shift > Y_MAX) begin
            w_y_sat = 32'h7FFF_FFFF;
        end else if (w_shift < Y_MIN) begin
            w_y_sat = 32'h8000_0000;
        end else begin
            w_y_sat = w_shift[31:0];
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // branch reads the values from before the edge and the order of
    // statements inside the block does not matter.
    // NOTE: the datapath registers are reset together with the control
    // registers, so the outputs have defined values straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_e         <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x        <= x;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_NORM;
                    end
                end

                ST_NORM: begin
                    if (r_x == 32'd0) begin
                        r_y         <= 32'h8000_0000;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_m     <= w_m_norm;
                        r_e     <= w_e;
                        r_acc   <= LN2_Q30;
                        r_k     <= 5'd1;
                        r_state <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    if (w_take) begin
                        r_m   <= w_t[31:0];
                        r_acc <= r_acc - ln_tab(r_k);
                    end
                    if (r_k == 5'(ITER)) begin
                        r_state <= ST_FINAL;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                end

                ST_FINAL: begin
                    r_y         <= w_y_sat;
                    r_err       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    // Ready rises on the release edge itself, so the next
                    // operand cannot be taken in the same cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign err       = r_err;

endmodule

// File: tb/tb_ln_fixed.sv
// ---------------------------------------------------------------------------
// tb_ln_fixed -- self-checking bench for ln_fixed.
// Expected results are queued when an operand is driven and compared when
// the block presents its result.
// ---------------------------------------------------------------------------
module tb_ln_fixed;

    localparam int ITER = 20;
`ifdef LN_FIXED_ROUND_EN
    localparam int TOL = 2;
`else
    localparam int TOL = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        err;

    typedef struct {
        logic [31:0] xv;
        int          exp_y;
        logic        exp_err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ln_fixed #(.ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol);
        longint d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ln_model(input logic [31:0] xv);
        real r;
        r = $ln(real'(xv) / 65536.0) * 65536.0;
        return $rtoi($floor(r + 0.5));
    endfunction

    task automatic start_op(input logic [31:0] xv, input int exp_y, input logic exp_err);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", longint'(in_ready), 1, 0);
        x        = xv;
        in_valid = 1'b1;
        e.xv      = xv;
        e.exp_y   = exp_y;
        e.exp_err = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = $urandom;   // must be ignored while busy
    endtask

    task automatic wait_result(input logic [31:0] xv);
        exp_t e;
        int   lat;
        int   exp_lat;
        exp_lat = (xv == 32'd0) ? 1 : ITER + 2;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        check("latency", lat, exp_lat, 0);
        check("sb_nonempty", longint'(sb.size() > 0), 1, 0);
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("y", longint'($signed(y)), e.exp_y, e.exp_err ? 0 : TOL);
            check("err", longint'(err), longint'(e.exp_err), 0);
            check("in_ready_busy", longint'(in_ready), 0, 0);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_clear", longint'(out_valid), 0, 0);
        check("in_ready_after", longint'(in_ready), 1, 0);
    endtask

    task automatic run_op(input logic [31:0] xv, input int exp_y, input logic exp_err);
        start_op(xv, exp_y, exp_err);
        wait_result(xv);
        release_out();
    endtask

    initial begin
        logic [31:0] xr;
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1, 0);
        check("rst_out_valid", longint'(out_valid), 0, 0);
        check("rst_y", longint'(y), 0, 0);
        check("rst_err", longint'(err), 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed values.
        run_op(32'h0001_0000, 0, 1'b0);
        run_op(32'h0002_0000, 45426, 1'b0);
        run_op(32'h0002_B7E1, 65536, 1'b0);
        run_op(32'h0000_8000, -45426, 1'b0);
        run_op(32'h0000_0001, -726817, 1'b0);
        run_op(32'hFFFF_FFFF, 726817, 1'b0);
        run_op(32'h0000_0000, int'(32'h8000_0000), 1'b1);

        // Backpressure: result held for 10 cycles, a stray in_valid ignored.
        start_op(32'h0002_0000, 45426, 1'b0);
        wait_result(32'h0002_0000);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            x        = 32'h0005_0000;
            @(posedge clk); #1;
            check("bp_out_valid", longint'(out_valid), 1, 0);
            check("bp_y", longint'($signed(y)), 45426, TOL);
            check("bp_in_ready", longint'(in_ready), 0, 0);
        end
        in_valid = 1'b0;
        release_out();
        run_op(32'h0000_8000, -45426, 1'b0);

        // Reset during the ITER phase (edge 6 after accept is step k=5).
        start_op(32'h0003_0000, ln_model(32'h0003_0000), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", longint'(in_ready), 1, 0);
        check("midrst_out_valid", longint'(out_valid), 0, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0, 0);
        run_op(32'h0002_0000, 45426, 1'b0);

        // Randomised operands across the full exponent range.
        for (int i = 0; i < 1000; i++) begin
            xr = $urandom >> $urandom_range(0, 31);
            if (xr == 32'd0) xr = 32'd1;
            run_op(xr, ln_model(xr), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
